// File: rtl/img_rd_tx.sv
// Uploads a stored RGB565 frame from the RAM spare read port to uart_byte_tx, high byte first.
// First send_go RD_LATENCY+1 clocks after each read strobe; every byte waits on tx_done; abort cancels.
module img_rd_tx #(
    parameter int ADDR_W     = 16,
    parameter int PIXELS     = 65536,
    parameter int RD_LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [15:0]       ram_rd_data,
    output logic [7:0]        tx_data,
    output logic              send_go,
    input  logic              tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        NEXT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
    localparam logic [1:0]        LAT_LOAD  = 2'(RD_LATENCY - 1);

    state_t      state;
    state_t      state_n;
    logic [1:0]  lat_cnt;
    logic [15:0] pixel;
    logic        is_last;
    logic        abort_hit;
    logic        start_hit;

    assign is_last   = (ram_rd_addr == LAST_ADDR);
    assign abort_hit = abort && (state != IDLE);
    assign start_hit = start && (state == IDLE);

    always_comb begin
        state_n = state;
        if (abort_hit) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_n = READ;
                READ:    state_n = LATCH;
                LATCH:   if (lat_cnt == 2'd0) state_n = SEND_HI;
                SEND_HI: state_n = WAIT_HI;
                WAIT_HI: if (tx_done) state_n = SEND_LO;
                SEND_LO: state_n = WAIT_LO;
                WAIT_LO: if (tx_done) state_n = NEXT;
                NEXT:    state_n = is_last ? IDLE : READ;
                default: state_n = IDLE;
            endcase
        end
    end

    // Every output is a register loaded from the next state, so it is valid in the cycle the state is entered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            tx_data     <= '0;
            send_go     <= 1'b0;
            lat_cnt     <= '0;
            pixel       <= '0;
        end else begin
            state     <= state_n;
            busy      <= (state_n != IDLE);
            done      <= (state_n == NEXT) && is_last;
            ram_rd_en <= (state_n == READ);
            send_go   <= (state_n == SEND_HI) || (state_n == SEND_LO);

            if (state == READ) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == LATCH) && (lat_cnt != 2'd0)) begin
                lat_cnt <= lat_cnt - 2'd1;
            end

            if ((state == LATCH) && (lat_cnt == 2'd0)) begin
                pixel <= ram_rd_data;
            end

            // SEND_HI is entered straight from LATCH, so the high byte comes off the read bus directly.
            if (state_n == SEND_HI) begin
                tx_data <= ram_rd_data[15:8];
            end else if (state_n == SEND_LO) begin
                tx_data <= pixel[7:0];
            end

            if (abort_hit || start_hit) begin
                ram_rd_addr <= '0;
            end else if ((state == NEXT) && !is_last) begin
                ram_rd_addr <= ram_rd_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_img_rd_tx.sv
// Drives two uploaders (4 px / latency 1, and a full 16-entry space / latency 3) with a RAM and UART model.
module tb_img_rd_tx;

    localparam int NI   = 2;
    localparam int CAPN = 1024;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    logic        Clk;
    logic        Reset_n;
    logic        start    [NI];
    logic        abort    [NI];
    logic        inj      [NI];
    logic        busy     [NI];
    logic        done     [NI];
    logic        rd_en    [NI];
    logic        send_go  [NI];
    logic        fire     [NI];
    logic        tx_done  [NI];
    logic [15:0] rd_addr  [NI];
    logic [15:0] rd_data  [NI];
    logic [7:0]  tx_data  [NI];
    logic [15:0] addr0;
    logic [3:0]  addr1;

    // Model state (written only by the model process)
    logic [15:0] hist [NI][4];
    logic [7:0]  cap  [NI][CAPN];
    logic [7:0]  last_tx [NI];
    int cyc;
    int cnt [NI], en_cyc [NI], prev_addr [NI], cap_n [NI];
    int n_en [NI], n_go [NI], n_done [NI], n_gap_bad [NI], n_dec [NI], n_ovl [NI], n_hold [NI];
    int last_fire_cyc [NI], done_cyc [NI], done_addr [NI];
    bit first_pend [NI];

    // Stimulus state (written only by the main process)
    logic [15:0] mem [NI][16];
    bit          fixed_dly [NI];
    logic [7:0]  exp_q [$];
    int tests, fails;
    int s_cap, s_en, s_go, s_done, s_gap, s_dec, s_ovl, s_hold;

    assign rd_addr[0] = addr0;
    assign rd_addr[1] = {12'd0, addr1};
    assign tx_done[0] = fire[0] | inj[0];
    assign tx_done[1] = fire[1] | inj[1];

    img_rd_tx #(.ADDR_W(16), .PIXELS(4), .RD_LATENCY(1)) u_dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start[0]), .abort(abort[0]),
        .busy(busy[0]), .done(done[0]), .ram_rd_en(rd_en[0]), .ram_rd_addr(addr0),
        .ram_rd_data(rd_data[0]), .tx_data(tx_data[0]), .send_go(send_go[0]), .tx_done(tx_done[0])
    );

    img_rd_tx #(.ADDR_W(4), .PIXELS(16), .RD_LATENCY(3)) u_dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start[1]), .abort(abort[1]),
        .busy(busy[1]), .done(done[1]), .ram_rd_en(rd_en[1]), .ram_rd_addr(addr1),
        .ram_rd_data(rd_data[1]), .tx_data(tx_data[1]), .send_go(send_go[1]), .tx_done(tx_done[1])
    );

    function automatic int pix_of(input int g);
        return (g == 0) ? 4 : 16;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    // RAM with RD_LATENCY pipeline (junk when not read) and a UART answering each send_go after a delay.
    initial begin
        cyc = 0;
        for (int g = 0; g < NI; g++) begin
            fire[g] = 1'b0; rd_data[g] = 16'hDEAD; cnt[g] = 0; en_cyc[g] = 0; prev_addr[g] = -1;
            cap_n[g] = 0; n_en[g] = 0; n_go[g] = 0; n_done[g] = 0; n_gap_bad[g] = 0; n_dec[g] = 0;
            n_ovl[g] = 0; n_hold[g] = 0; last_fire_cyc[g] = 0; done_cyc[g] = 0; done_addr[g] = 0;
            first_pend[g] = 1'b0; last_tx[g] = 8'h00;
            for (int k = 0; k < 4; k++) hist[g][k] = 16'hDEAD;
        end
        forever begin
            @(negedge Clk);
            cyc++;
            for (int g = 0; g < NI; g++) begin
                fire[g] = 1'b0;
                if (cnt[g] > 0) begin
                    cnt[g]--;
                    if (cnt[g] == 0) begin
                        fire[g] = 1'b1;
                        last_fire_cyc[g] = cyc;
                    end
                end
                if (cnt[g] > 0 && busy[g] && tx_data[g] != last_tx[g]) n_hold[g]++;
                if (send_go[g]) begin
                    n_go[g]++;
                    if (cnt[g] > 0 || fire[g]) n_ovl[g]++;
                    if (cap_n[g] < CAPN) cap[g][cap_n[g]] = tx_data[g];
                    cap_n[g]++;
                    last_tx[g] = tx_data[g];
                    cnt[g] = fixed_dly[g] ? 10 : int'($urandom_range(12, 1));
                    if (first_pend[g]) begin
                        if (cyc - en_cyc[g] != lat_of(g) + 1) n_gap_bad[g]++;
                        first_pend[g] = 1'b0;
                    end
                end
                if (rd_en[g]) begin
                    n_en[g]++;
                    en_cyc[g] = cyc;
                    first_pend[g] = 1'b1;
                    if (int'(rd_addr[g]) < prev_addr[g]) n_dec[g]++;
                    prev_addr[g] = int'(rd_addr[g]);
                end else if (!busy[g]) begin
                    prev_addr[g] = -1;
                end
                for (int k = 3; k > 0; k--) hist[g][k] = hist[g][k-1];
                hist[g][0] = rd_en[g] ? mem[g][rd_addr[g][3:0]] : 16'hDEAD;
                rd_data[g] = hist[g][lat_of(g)];
                if (done[g]) begin
                    n_done[g]++;
                    done_cyc[g] = cyc;
                    done_addr[g] = int'(rd_addr[g]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int g, input string tag);
        check({tag, " busy"},     int'(busy[g]),    0);
        check({tag, " done"},     int'(done[g]),    0);
        check({tag, " rd_en"},    int'(rd_en[g]),   0);
        check({tag, " send_go"},  int'(send_go[g]), 0);
        check({tag, " rd_addr"},  int'(rd_addr[g]), 0);
        check({tag, " tx_data"},  int'(tx_data[g]), 0);
    endtask

    task automatic begin_frame(input int g);
        s_cap = cap_n[g]; s_en = n_en[g]; s_go = n_go[g]; s_done = n_done[g];
        s_gap = n_gap_bad[g]; s_dec = n_dec[g]; s_ovl = n_ovl[g]; s_hold = n_hold[g];
        @(negedge Clk); start[g] = 1'b1;
        @(negedge Clk); start[g] = 1'b0;
    endtask

    task automatic end_frame(input int g, input string tag);
        int t;
        int nb;
        t = 0;
        while (n_done[g] == s_done && t < 5000) begin
            @(negedge Clk);
            t++;
        end
        check({tag, " finished in budget"}, int'(t < 5000), 1);
        repeat (2) @(negedge Clk);
        nb = cap_n[g] - s_cap;
        check({tag, " byte count"}, nb, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < nb && s_cap + i < CAPN; i++)
            check($sformatf("%s byte%0d", tag, i), int'(cap[g][s_cap + i]), int'(exp_q[i]));
        check({tag, " done pulses"},         n_done[g] - s_done, 1);
        check({tag, " done after tx_done"},  done_cyc[g] - last_fire_cyc[g], 1);
        check({tag, " busy after"},          int'(busy[g]), 0);
        check({tag, " read strobes"},        n_en[g] - s_en, pix_of(g));
        check({tag, " read-to-send gap"},    n_gap_bad[g] - s_gap, 0);
        check({tag, " addr decrease"},       n_dec[g] - s_dec, 0);
        check({tag, " send before tx_done"}, n_ovl[g] - s_ovl, 0);
        check({tag, " tx_data held"},        n_hold[g] - s_hold, 0);
        check({tag, " addr at done"},        done_addr[g], pix_of(g) - 1);
        check({tag, " final addr"},          int'(rd_addr[g]), pix_of(g) - 1);
    endtask

    task automatic run_frame(input int g, input string tag);
        begin_frame(g);
        end_frame(g, tag);
    endtask

    task automatic exp_from_mem(input int g);
        exp_q.delete();
        for (int i = 0; i < pix_of(g); i++) begin
            exp_q.push_back(8'(mem[g][i] >> 8));
            exp_q.push_back(8'(mem[g][i] & 16'h00FF));
        end
    endtask

    initial begin
        vec_t vt [4];
        int   t, k, idle_bad;
        tests = 0; fails = 0;
        vt[0] = '{16'h1234, 8'h12, 8'h34};
        vt[1] = '{16'hABCD, 8'hAB, 8'hCD};
        vt[2] = '{16'h0000, 8'h00, 8'h00};
        vt[3] = '{16'hFFFF, 8'hFF, 8'hFF};
        for (int g = 0; g < NI; g++) begin
            start[g] = 1'b0; abort[g] = 1'b0; inj[g] = 1'b0; fixed_dly[g] = 1'b1;
            for (int i = 0; i < 16; i++) mem[g][i] = 16'(i * 16'h0101);
        end
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        check_idle(0, "reset0");
        check_idle(1, "reset1");
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Basic frame from the vector table
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            mem[0][i] = vt[i].word;
            exp_q.push_back(vt[i].hi);
            exp_q.push_back(vt[i].lo);
        end
        run_frame(0, "basic");

        // Latency 3 with the same leading pixels, rest i*0x0101
        for (int i = 0; i < 4; i++) mem[1][i] = vt[i].word;
        exp_from_mem(1);
        run_frame(1, "latency");

        // Full 16-entry address space
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            mem[1][i] = 16'(i * 16'h0101);
            exp_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        run_frame(1, "fulladdr");

        // Busy protection: second start and a spurious tx_done during SEND_HI of byte 3
        exp_from_mem(0);
        begin_frame(0);
        k = 0; t = 0;
        while (k < 3 && t < 2000) begin
            @(negedge Clk); t++;
            if (send_go[0]) k++;
        end
        check("busyprot reach byte3", k, 3);
        start[0] = 1'b1; inj[0] = 1'b1;
        @(negedge Clk);
        start[0] = 1'b0; inj[0] = 1'b0;
        end_frame(0, "busyprot");

        // Abort while waiting on byte 3
        begin_frame(0);
        k = 0; t = 0;
        while (k < 3 && t < 2000) begin
            @(negedge Clk); t++;
            if (send_go[0]) k++;
        end
        check("abort reach byte3", k, 3);
        @(negedge Clk); abort[0] = 1'b1;
        @(negedge Clk); abort[0] = 1'b0;
        check("abort busy next clock", int'(busy[0]),    0);
        check("abort send_go",         int'(send_go[0]), 0);
        check("abort rd_en",           int'(rd_en[0]),   0);
        check("abort rd_addr",         int'(rd_addr[0]), 0);
        t = 0;
        while (cnt[0] != 0 && t < 100) begin
            @(negedge Clk); t++;
        end
        repeat (10) @(negedge Clk);
        check("abort no further send_go", n_go[0] - s_go, 3);
        check("abort no done",            n_done[0] - s_done, 0);
        run_frame(0, "restart");

        // Reset asserted during WAIT_LO of the first pixel
        begin_frame(0);
        k = 0; t = 0;
        while (k < 2 && t < 2000) begin
            @(negedge Clk); t++;
            if (send_go[0]) k++;
        end
        check("midreset reach byte2", k, 2);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1 check_idle(0, "midreset");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        idle_bad = 0;
        repeat (30) begin
            @(negedge Clk);
            if (busy[0] || send_go[0] || rd_en[0] || done[0]) idle_bad++;
        end
        check("postreset stays idle", idle_bad, 0);
        check("postreset no done",    n_done[0] - s_done, 0);
        run_frame(0, "afterreset");

        // Random pixel data and random UART delays
        for (int g = 0; g < NI; g++) fixed_dly[g] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int g = 0; g < NI; g++) begin
                for (int i = 0; i < pix_of(g); i++) mem[g][i] = 16'($urandom);
                exp_from_mem(g);
                run_frame(g, $sformatf("rand%0d_%0d", r, g));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/img_rd_tx.md
Name: img_rd_tx

Overview:
Reads a stored 16-bit RGB565 image out of the display RAM's spare read port and streams it as bytes to the UART transmitter. This is the upload direction: the image comes back out of the board to the PC. It sits between the dual-port RAM and uart_byte_tx, in the same clock domain as the receive/write path. Each pixel is sent as two bytes, high byte first, which is the byte order the receive path uses to assemble pixels.

Parameters:
ADDR_W, 16, RAM address width.
PIXELS, 65536, number of pixels sent per frame (1..2^ADDR_W); the frame covers addresses 0..PIXELS-1.
RD_LATENCY, 1, RAM read latency in clocks (1..3).

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a frame upload when idle
abort  input  1  single-cycle pulse; cancels the upload in progress
busy  output  1  high while an upload is in progress
done  output  1  single-cycle pulse after the last byte's tx_done
ram_rd_en  output  1  RAM read strobe
ram_rd_addr  output  ADDR_W  RAM read address
ram_rd_data  input  16  RAM read data, valid RD_LATENCY clocks after ram_rd_en
tx_data  output  8  byte to uart_byte_tx, held stable until tx_done
send_go  output  1  single-cycle request to uart_byte_tx
tx_done  input  1  single-cycle pulse from uart_byte_tx when a byte has finished

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-low (Reset_n).
- Reset values: busy=0, done=0, ram_rd_en=0, ram_rd_addr=0, tx_data=0, send_go=0. The FSM resets to IDLE and the latency counter and pixel register reset to 0.
- All outputs are registered.
- FSM states are IDLE, READ, LATCH, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT.
- IDLE:
  - start=1 → ram_rd_addr<=0, busy<=1, go to READ.
  - abort is ignored in IDLE.
- READ:
  - ram_rd_en=1 for exactly one cycle T; the latency counter is loaded.
  - Then go to LATCH.
- LATCH:
  - Waits until ram_rd_data is valid, i.e. RD_LATENCY clocks after cycle T.
  - Captures ram_rd_data into the 16-bit pixel register at the end of cycle T+RD_LATENCY.
  - Then go to SEND_HI.
- SEND_HI:
  - For one cycle, send_go=1 and tx_data=pixel[15:8].
  - For RD_LATENCY=1, send_go is high in cycle T+2.
  - Then go to WAIT_HI.
- WAIT_HI:
  - Holds tx_data until tx_done=1, then goes to SEND_LO.
  - A tx_done in the same cycle as entering WAIT_HI counts.
- SEND_LO / WAIT_LO: identical to SEND_HI / WAIT_HI, using pixel[7:0].
- NEXT:
  - If ram_rd_addr==PIXELS-1: done=1 for one cycle, busy<=0, go to IDLE. The address is held and does not wrap.
  - Otherwise: ram_rd_addr<=ram_rd_addr+1, go to READ.
- Address arithmetic is ADDR_W-bit unsigned. The terminal compare uses PIXELS-1, so PIXELS=2^ADDR_W ends at all-ones without overflow.
- start while busy=1 is ignored; there is no restart and no queuing.
- tx_done outside WAIT_HI/WAIT_LO is ignored.
- abort while busy:
  - Next state is IDLE, busy<=0, send_go<=0, ram_rd_en<=0, ram_rd_addr<=0. No done pulse.
  - A byte already handed to uart_byte_tx completes on the line; its tx_done is ignored.
- abort and start in the same cycle while busy: abort wins.
- Reset mid-upload: everything returns to reset values immediately, with no done pulse.
- Exactly 2*PIXELS send_go pulses per completed frame.
- send_go is never reasserted before tx_done for the previous byte.
- Throughput is bounded by the UART. Per-pixel overhead outside the UART waits is RD_LATENCY+4 clocks.

Test Plan:
- Basic frame:
  - Setup: PIXELS=4, RAM preloaded with 0x1234, 0xABCD, 0x0000, 0xFFFF; tx_done model fires 10 clocks after each send_go.
  - Stimulus: start.
  - Required: bytes 12 34 AB CD 00 00 FF FF in order; done pulses once, 1 clock after the 8th tx_done; busy then 0.
- Latency:
  - Setup: RD_LATENCY=3, same preload.
  - Required: identical byte stream; first send_go exactly 4 clocks after the ram_rd_en pulse; ram_rd_en count = 4.
- Busy protection:
  - Stimulus: start again mid-frame; spurious tx_done while in SEND_HI.
  - Required: no restart; sequence unchanged; ram_rd_addr never decreases.
- Abort:
  - Stimulus: abort while waiting on byte 3.
  - Required: busy=0 next clock; no done; no further send_go even when the pending tx_done arrives; a subsequent start begins at address 0 with byte 12.
- Full address space:
  - Setup: ADDR_W=4, PIXELS=16, RAM[i]=i*0x0101.
  - Required: 32 bytes 00 00 01 01 … 0F 0F; final ram_rd_addr=15, no wrap to 0 before done.
- Reset mid-frame:
  - Stimulus: Reset_n low during WAIT_LO.
  - Required: all outputs at reset values asynchronously; after release, outputs stay idle until the next start.
